alu_shift_seq: RTL and testbench
================================

ALU_SHIFT_SEQ -- requirements
Module: alu_shift_seq

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port start  input  1  request strobe; accepted only when busy=0.
REQ-004 SHALL have port op  input  4  AluOp code of the requested operation.
REQ-005 SHALL have port operand  input  16  initial A operand / shift source.
REQ-006 SHALL have port operand_b  input  16  B operand for ADD/SUB.
REQ-007 SHALL have port count  input  8  requested iteration count (shift/rotate amount).
REQ-008 SHALL have port busy  output  1  high from the cycle after acceptance until done.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port result  output  16  final value; held until the next accepted start.
REQ-011 SHALL have port alu_op  output  4  op driven to the external ALU.
REQ-012 SHALL have port alu_a  output  16  A operand to the ALU (accumulator).
REQ-013 SHALL have port alu_b  output  16  B operand to the ALU (latched operand_b).
REQ-014 SHALL have port alu_r  input  16  combinational ALU result.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; busy=1 in RUN and DONE.
REQ-016 In IDLE with start=1: latch op, operand into acc, operand_b, and effective count N; next state RUN if N>0, else DONE.
REQ-017 Effective N: ADD/SUB -> 1 regardless of count; SHL/SHR/ROL/ROR -> count (see REQ-026); undefined op codes -> 0.
REQ-018 In RUN each cycle: acc <= alu_r, N <= N-1; transition to DONE when N==1.
REQ-019 In DONE: result <= acc, done=1 for exactly one cycle, return to IDLE.
REQ-020 Latency: start accepted at edge T -> done high in cycle T+N+1; next start accepted in the cycle after done.
REQ-021 start while busy=1 (RUN or DONE) SHALL be ignored with no state change.
REQ-022 alu_op, alu_a, alu_b SHALL be registered/latched values, stable throughout RUN.
REQ-023 N==0 SHALL yield result=operand unchanged.

Reset
REQ-024 reset_n low, at any time including mid-RUN: state=IDLE, busy=0, done=0, result=0, acc=0, alu_b=0, N=0, alu_op=ALUOP_ADD.
REQ-025 The first start after reset_n deasserts SHALL be accepted normally.

Configuration
REQ-026 Macro ALU_SHIFT_SEQ_COUNT_MASK_EN: defined -> shift/rotate N = count[4:0] (0..31); undefined -> N = full count[7:0] (0..255).

Structure
REQ-027 The AluOp enum and the sequencer state enum SHALL live in a shared package (alu_pkg) used by both alu and alu_shift_seq.
REQ-028 No sub-module; the ALU is instantiated alongside this block in the parent and connected via alu_op/alu_a/alu_b/alu_r.

Verification
REQ-029 SHL, operand=0x0001, count=4 -> result=0x0010, done at T+5, busy high T+1..T+5.
REQ-030 ROR, operand=0xABCD, count=0 -> result=0xABCD, done at T+1.
REQ-031 ADD, operand=0x1234, operand_b=0x0001, count=7 -> result=0x1235, done at T+2.
REQ-032 SHL, operand=0x8001, count=33: with macro -> N=1, result=0x0002; without -> 33 iterations, result=0x0000.
REQ-033 Second start pulsed mid-RUN -> ignored; first result and done timing unchanged.
REQ-034 reset_n asserted mid-RUN of SHR count=10 -> busy=0, done never pulses, result=0; fresh SHR 0x0100 count=8 -> result=0x0001.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the shift/ALU sequencer and its companion ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    ALUOP_ADD = 4'd0,
    ALUOP_SUB = 4'd1,
    ALUOP_SHL = 4'd2,
    ALUOP_SHR = 4'd3,
    ALUOP_ROL = 4'd4,
    ALUOP_ROR = 4'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_e;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 8;

endpackage

// File: rtl/alu.sv
// Combinational single-step ALU: ADD/SUB use b, shifts and rotates move by one bit.
module alu
  import alu_pkg::*;
(
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] r_o
);

  always_comb begin
    r_o = a_i;
    case (op_i)
      ALUOP_ADD: r_o = a_i + b_i;
      ALUOP_SUB: r_o = a_i - b_i;
      ALUOP_SHL: r_o = {a_i[DATA_W-2:0], 1'b0};
      ALUOP_SHR: r_o = {1'b0, a_i[DATA_W-1:1]};
      ALUOP_ROL: r_o = {a_i[DATA_W-2:0], a_i[DATA_W-1]};
      ALUOP_ROR: r_o = {a_i[0], a_i[DATA_W-1:1]};
      default:   r_o = a_i;
    endcase
  end

endmodule

// File: rtl/alu_shift_seq.sv
// Iterates an external one-step ALU N times over an accumulator.
// ALU_SHIFT_SEQ_COUNT_MASK_EN: when defined, shift/rotate amounts use count[4:0] only.
//
// state | meaning
// IDLE  | waiting for start; result holds last value
// RUN   | one ALU step per cycle, N counts down to 1
// DONE  | done pulse, result valid, start still ignored
module alu_shift_seq
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] operand,
  input  logic [DATA_W-1:0] operand_b,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_r
);

  seq_state_e        state_q;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] b_q;
  logic [CNT_W-1:0]  n_q;
  logic [CNT_W-1:0]  n_d;
  logic [DATA_W-1:0] result_q;
  logic              busy_q;
  logic              done_q;

  always_comb begin
    n_d = '0;
    case (op)
      ALUOP_ADD, ALUOP_SUB: n_d = 8'd1;
      ALUOP_SHL, ALUOP_SHR, ALUOP_ROL, ALUOP_ROR: begin
`ifdef ALU_SHIFT_SEQ_COUNT_MASK_EN
        n_d = {3'b000, count[4:0]};
`else
        n_d = count;
`endif
      end
      default: n_d = '0;
    endcase
  end

  // result/done are loaded on the edge entering DONE so they appear together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= SEQ_IDLE;
      op_q     <= ALUOP_ADD;
      acc_q    <= '0;
      b_q      <= '0;
      n_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        SEQ_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q   <= op;
            acc_q  <= operand;
            b_q    <= operand_b;
            n_q    <= n_d;
            busy_q <= 1'b1;
            if (n_d == '0) begin
              state_q  <= SEQ_DONE;
              result_q <= operand;
              done_q   <= 1'b1;
            end else begin
              state_q <= SEQ_RUN;
            end
          end
        end
        SEQ_RUN: begin
          acc_q <= alu_r;
          n_q   <= n_q - 8'd1;
          if (n_q == 8'd1) begin
            state_q  <= SEQ_DONE;
            result_q <= alu_r;
            done_q   <= 1'b1;
          end
        end
        SEQ_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= SEQ_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= SEQ_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign alu_op = op_q;
  assign alu_a  = acc_q;
  assign alu_b  = b_q;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Randomized self-checking bench for alu_shift_seq with its ALU in the loop.
module tb_alu_shift_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [15:0] operand = '0;
  logic [15:0] operand_b = '0;
  logic [7:0]  count = '0;
  logic        busy, done;
  logic [15:0] result, alu_a, alu_b, alu_r;
  logic [3:0]  alu_op;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_shift_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .operand(operand), .operand_b(operand_b), .count(count),
    .busy(busy), .done(done), .result(result),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r)
  );

  alu u_alu (.op_i(alu_op), .a_i(alu_a), .b_i(alu_b), .r_o(alu_r));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int model_n(input logic [3:0] o, input logic [7:0] c);
    if (o == ALUOP_ADD || o == ALUOP_SUB) return 1;
    if (o >= ALUOP_SHL && o <= ALUOP_ROR) begin
`ifdef ALU_SHIFT_SEQ_COUNT_MASK_EN
      return int'(c) % 32;
`else
      return int'(c);
`endif
    end
    return 0;
  endfunction

  // Whole-operation result: shift by n at once, rotate by n mod 16.
  function automatic logic [15:0] model_res(input logic [3:0] o, input logic [15:0] a,
                                            input logic [15:0] b, input int n);
    int unsigned x, r;
    x = a;
    r = n % 16;
    case (o)
      ALUOP_ADD: return a + b;
      ALUOP_SUB: return a - b;
      ALUOP_SHL: return (n >= 16) ? 16'h0 : 16'((x << n) & 32'hFFFF);
      ALUOP_SHR: return (n >= 16) ? 16'h0 : 16'(x >> n);
      ALUOP_ROL: return 16'(((x << r) | (x >> (16 - r))) & 32'hFFFF);
      ALUOP_ROR: return 16'(((x >> r) | (x << (16 - r))) & 32'hFFFF);
      default:   return a;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [3:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [7:0] c, input bit poke);
    int en, lat;
    logic [15:0] er;
    en = model_n(o, c);
    er = model_res(o, a, b, en);
    @(negedge clk);
    chk({tag, ".idle"}, {30'd0, busy, done}, 32'd0);
    start = 1'b1; op = o; operand = a; operand_b = b; count = c;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (poke && lat == 2) start = 1'b0;
      if (done) break;
      chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
      if (lat == 1) begin
        chk({tag, ".aluop"}, {28'd0, alu_op}, {28'd0, o});
        chk({tag, ".alub"}, {16'd0, alu_b}, {16'd0, b});
        if (poke) begin
          start = 1'b1; op = ALUOP_SUB; operand = ~a; operand_b = 16'h5555; count = 8'd2;
        end
      end
      if (lat > 300) begin
        chk({tag, ".timeout"}, 32'(lat), 32'(en + 1));
        start = 1'b0;
        return;
      end
    end
    start = 1'b0;
    chk({tag, ".lat"}, 32'(lat), 32'(en + 1));
    chk({tag, ".res"}, {16'd0, result}, {16'd0, er});
    chk({tag, ".busydn"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk({tag, ".pulse"}, {30'd0, busy, done}, 32'd0);
    chk({tag, ".hold"}, {16'd0, result}, {16'd0, er});
  endtask

  initial begin
    logic [3:0] ro;
    logic [7:0] rc;
    repeat (3) @(negedge clk);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.res", {16'd0, result}, 32'd0);
    chk("rst.alub", {16'd0, alu_b}, 32'd0);
    chk("rst.alua", {16'd0, alu_a}, 32'd0);
    chk("rst.aluop", {28'd0, alu_op}, {28'd0, ALUOP_ADD});
    reset_n = 1'b1;

    run_op("shl4", ALUOP_SHL, 16'h0001, 16'h0000, 8'd4, 1'b0);
    run_op("ror0", ALUOP_ROR, 16'hABCD, 16'h0000, 8'd0, 1'b0);
    run_op("add7", ALUOP_ADD, 16'h1234, 16'h0001, 8'd7, 1'b0);
    run_op("shl33", ALUOP_SHL, 16'h8001, 16'h0000, 8'd33, 1'b0);
    run_op("poke", ALUOP_ROL, 16'h8421, 16'h0000, 8'd6, 1'b1);
    run_op("sub", ALUOP_SUB, 16'h0000, 16'h0001, 8'd0, 1'b0);
    run_op("undef", 4'd9, 16'h7E57, 16'h1111, 8'd20, 1'b0);

    // Reset in the middle of a long shift.
    @(negedge clk);
    start = 1'b1; op = ALUOP_SHR; operand = 16'hFFFF; count = 8'd10;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst.busy", {31'd0, busy}, 32'd0);
    chk("midrst.res", {16'd0, result}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (15) begin
        @(negedge clk);
        if (done || busy) seen++;
      end
      chk("midrst.quiet", 32'(seen), 32'd0);
    end
    run_op("shr8", ALUOP_SHR, 16'h0100, 16'h0000, 8'd8, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(0, 7));
      rc = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
      run_op("rnd", ro, 16'($urandom), 16'($urandom), rc, 1'($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
